// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption sequencer: steps a shared round datapath through
// key addition, NR-1 full rounds and the final round, fetching one round key per step.
module aes_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       load_en,
  output logic       rk_req,
  output logic [3:0] rk_idx,
  input  logic       rk_ack,
  output logic       state_en,
  output logic [1:0] path_sel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic [3:0] round
);

  localparam int unsigned RW = 4;
  localparam logic [RW-1:0] NR_L = RW'(NR);

  localparam logic [1:0] SEL_ARK   = 2'b00;
  localparam logic [1:0] SEL_FULL  = 2'b01;
  localparam logic [1:0] SEL_FINAL = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_KEYREQ,
    S_EXEC,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic          in_ready_q, in_ready_d;
  logic          rk_req_q, rk_req_d;
  logic [RW-1:0] rk_idx_q, rk_idx_d;
  logic          state_en_q, state_en_d;
  logic [1:0]    path_sel_q, path_sel_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;

  // Next state, then outputs decoded from the next state so they are flopped yet Moore.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_KEYREQ;
          round_d = '0;
        end
      end
      S_KEYREQ: begin
        if (rk_ack) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (round_q == NR_L) begin
          state_d = S_DONE;
        end else begin
          state_d = S_KEYREQ;
          round_d = round_q + RW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          round_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        round_d = '0;
      end
    endcase

    in_ready_d  = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    rk_req_d    = (state_d == S_KEYREQ);
    rk_idx_d    = round_d;
    state_en_d  = (state_d == S_EXEC);
    out_valid_d = (state_d == S_DONE);
    path_sel_d  = SEL_ARK;
    if (state_d == S_EXEC) begin
      if (round_d == '0)        path_sel_d = SEL_ARK;
      else if (round_d == NR_L) path_sel_d = SEL_FINAL;
      else                      path_sel_d = SEL_FULL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      round_q     <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      rk_req_q    <= 1'b0;
      rk_idx_q    <= '0;
      state_en_q  <= 1'b0;
      path_sel_q  <= SEL_ARK;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      rk_req_q    <= rk_req_d;
      rk_idx_q    <= rk_idx_d;
      state_en_q  <= state_en_d;
      path_sel_q  <= path_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Capture strobe is the input handshake itself; held low while reset is applied.
  assign load_en   = in_valid & in_ready_q & ~rst;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign rk_req    = rk_req_q;
  assign rk_idx    = rk_idx_q;
  assign state_en  = state_en_q;
  assign path_sel  = path_sel_q;
  assign out_valid = out_valid_q;
  assign round     = round_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: NR=10 cycle table plus stall, backpressure,
// async-reset, NR=14 and back-to-back sequences.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_ready, load_en, rk_req, rk_ack, state_en, out_valid, out_ready, busy;
  logic [3:0] rk_idx, round;
  logic [1:0] path_sel;

  logic       iv_b, ir_b, le_b, rq_b, ack_b, se_b, ov_b, ordy_b, bz_b;
  logic [3:0] ix_b, rd_b;
  logic [1:0] ps_b;

  aes_round_ctrl #(.NR(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .load_en(load_en),
    .rk_req(rk_req), .rk_idx(rk_idx), .rk_ack(rk_ack), .state_en(state_en),
    .path_sel(path_sel), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .round(round)
  );

  aes_round_ctrl #(.NR(14)) dut14 (
    .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .load_en(le_b),
    .rk_req(rq_b), .rk_idx(ix_b), .rk_ack(ack_b), .state_en(se_b),
    .path_sel(ps_b), .out_valid(ov_b), .out_ready(ordy_b), .busy(bz_b),
    .round(rd_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pk(input logic ir, input logic le, input logic rq,
                                     input logic [3:0] ix, input logic se,
                                     input logic [1:0] ps, input logic ov,
                                     input logic bz, input logic [3:0] rd);
    return {ir, le, rq, ix, se, ps, ov, bz, rd};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       in_valid;
    logic       rk_ack;
    logic       out_ready;
    logic       in_ready;
    logic       load_en;
    logic       rk_req;
    logic [3:0] rk_idx;
    logic       state_en;
    logic [1:0] path_sel;
    logic       out_valid;
    logic       busy;
    logic [3:0] round;
  } vec_t;

  vec_t tbl[25];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   pulses, k3, first_ov, n_le, n_ir, n_ov, n00, n01, n10, maxrd;
    logic [1:0] last_ps, first_ps;
    logic [3:0] ixm;
    int   acc[$];

    // Expected cycle-by-cycle trace of one unstalled NR=10 block (cycle 0 = acceptance)
    for (int c = 0; c < 25; c++) begin
      v = '{default: 0};
      v.rk_ack    = 1'b1;
      v.out_ready = 1'b1;
      v.in_valid  = (c == 0);
      if (c == 0 || c == 24) begin
        v.in_ready = 1'b1;
        v.load_en  = (c == 0);
      end else if (c == 23) begin
        v.busy = 1'b1; v.out_valid = 1'b1; v.round = 4'd10;
      end else if (c % 2 == 1) begin
        v.busy = 1'b1; v.rk_req = 1'b1; v.round = 4'((c - 1) / 2); v.rk_idx = v.round;
      end else begin
        v.busy = 1'b1; v.state_en = 1'b1; v.round = 4'((c - 2) / 2);
        v.path_sel = (c == 2) ? 2'b00 : (c == 22) ? 2'b10 : 2'b01;
      end
      tbl[c] = v;
    end

    rst = 1'b1; in_valid = 1'b0; rk_ack = 1'b0; out_ready = 1'b0;
    iv_b = 1'b0; ack_b = 1'b0; ordy_b = 1'b0;
    @(negedge clk);
    check("reset_outputs", 32'(pk(in_ready, load_en, rk_req, rk_idx, state_en, path_sel,
                                   out_valid, busy, round)),
          32'(pk(1, 0, 0, 4'd0, 0, 2'b00, 0, 0, 4'd0)));
    next_cycle();
    rst = 1'b0;

    // Table-driven NR=10 block
    for (int c = 0; c < 25; c++) begin
      in_valid = tbl[c].in_valid; rk_ack = tbl[c].rk_ack; out_ready = tbl[c].out_ready;
      @(negedge clk);
      ixm = tbl[c].rk_req ? rk_idx : 4'd0;
      check($sformatf("tbl_cycle_%0d", c),
            32'(pk(in_ready, load_en, rk_req, ixm, state_en, path_sel, out_valid, busy, round)),
            32'(pk(tbl[c].in_ready, tbl[c].load_en, tbl[c].rk_req, tbl[c].rk_idx,
                   tbl[c].state_en, tbl[c].path_sel, tbl[c].out_valid, tbl[c].busy,
                   tbl[c].round)));
      next_cycle();
    end
    in_valid = 1'b0;

    // Key-schedule stall: rk_ack low for 5 cycles while round 3 key is requested
    in_valid = 1'b1; rk_ack = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("stall_accept", 32'(load_en), 32'd1);
    next_cycle();
    in_valid = 1'b0;
    pulses = 0; k3 = 0; first_ov = -1;
    for (int c = 1; c <= 30; c++) begin
      rk_ack = !(c >= 7 && c <= 11);
      @(negedge clk);
      if (state_en) pulses++;
      if (rk_req && rk_idx == 4'd3) k3++;
      if (out_valid && first_ov < 0) first_ov = c;
      next_cycle();
    end
    rk_ack = 1'b1;
    check("stall_state_en_pulses", 32'(pulses), 32'd11);
    check("stall_rk_idx3_cycles", 32'(k3), 32'd6);
    check("stall_out_valid_cycle", 32'(first_ov), 32'd28);

    // Output backpressure with in_valid held high; rk_ack also high in DONE
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    check("bp_accept", 32'(load_en), 32'd1);
    next_cycle();
    n_le = 0; n_ir = 0; n_ov = 0;
    for (int c = 1; c <= 28; c++) begin
      out_ready = (c >= 27);
      @(negedge clk);
      if (c <= 27) begin
        if (load_en)   n_le++;
        if (in_ready)  n_ir++;
        if (out_valid) n_ov++;
      end else begin
        check("bp_in_ready_after_hs", 32'(in_ready), 32'd1);
        check("bp_reaccept_load_en", 32'(load_en), 32'd1);
      end
      next_cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_no_load_while_busy", 32'(n_le), 32'd0);
    check("bp_in_ready_low_while_busy", 32'(n_ir), 32'd0);
    check("bp_out_valid_held_cycles", 32'(n_ov), 32'd5);
    repeat (23) next_cycle();
    @(negedge clk);
    check("bp_second_block_drained", 32'({in_ready, busy}), 32'b10);
    next_cycle();

    // Asynchronous reset in the middle of round-6 EXEC
    in_valid = 1'b1;
    @(negedge clk);
    check("rst_accept", 32'(load_en), 32'd1);
    next_cycle();
    in_valid = 1'b0;
    repeat (13) next_cycle();
    @(negedge clk);
    check("rst_exec6_before", 32'({state_en, round}), 32'({1'b1, 4'd6}));
    #1 rst = 1'b1;
    #1;
    check("rst_async_outputs",
          32'(pk(in_ready, load_en, rk_req, rk_idx, state_en, path_sel, out_valid, busy, round)),
          32'(pk(1, 0, 0, 4'd0, 0, 2'b00, 0, 0, 4'd0)));
    next_cycle();
    rst = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    check("rst_fresh_accept", 32'(load_en), 32'd1);
    next_cycle();
    in_valid = 1'b0;
    first_ov = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (out_valid && first_ov < 0) first_ov = c;
      next_cycle();
    end
    check("rst_fresh_latency", 32'(first_ov), 32'd23);

    // NR=14 instance
    iv_b = 1'b1; ack_b = 1'b1; ordy_b = 1'b1;
    @(negedge clk);
    check("nr14_accept", 32'(le_b), 32'd1);
    next_cycle();
    iv_b = 1'b0;
    pulses = 0; n00 = 0; n01 = 0; n10 = 0; maxrd = 0; first_ov = -1;
    last_ps = 2'b11; first_ps = 2'b11;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (se_b) begin
        if (pulses == 0) first_ps = ps_b;
        pulses++;
        last_ps = ps_b;
        if (ps_b == 2'b00) n00++;
        if (ps_b == 2'b01) n01++;
        if (ps_b == 2'b10) n10++;
      end
      if (int'(rd_b) > maxrd) maxrd = int'(rd_b);
      if (ov_b && first_ov < 0) first_ov = c;
      next_cycle();
    end
    check("nr14_state_en_pulses", 32'(pulses), 32'd15);
    check("nr14_sel_counts", 32'({8'(n00), 8'(n01), 8'(n10)}), 32'({8'd1, 8'd13, 8'd1}));
    check("nr14_first_last_sel", 32'({first_ps, last_ps}), 32'({2'b00, 2'b10}));
    check("nr14_max_round", 32'(maxrd), 32'd14);
    check("nr14_out_valid_cycle", 32'(first_ov), 32'd31);

    // Spurious rk_ack while idle, then back-to-back blocks
    rk_ack = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("idle_spurious_ack_%0d", c),
            32'(pk(in_ready, load_en, rk_req, rk_idx, state_en, path_sel, out_valid, busy, round)),
            32'(pk(1, 0, 0, 4'd0, 0, 2'b00, 0, 0, 4'd0)));
      next_cycle();
    end
    in_valid = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (load_en) acc.push_back(c);
      next_cycle();
    end
    in_valid = 1'b0;
    check("b2b_accept_count", 32'(acc.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < acc.size()) check($sformatf("b2b_accept_cycle_%0d", i), 32'(acc[i]), 32'(24 * i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
